// File: rtl/f2c_dma_scheduler.sv
// ----------------------------------------------------------------------------
// f2c_dma_scheduler
//
// Moves an FPGA->CPU data stream into a host-side ring buffer.
// The 64-bit source stream is cut into chunks of TLPS_PER_CHUNK memory-write
// TLPs, each carrying TLP_QWS payload beats. After each complete chunk, the new
// chunk write-pointer is posted to the host metrics buffer as a 1-DW write.
// A chunk is only started when the ring has a free slot. One slot is always
// left empty, so that a full ring can be told apart from an empty one.
//
// Ports
//   clk_in, rstn          application clock, synchronous active-low reset
//   dmaEnable_in          level enable; a rising edge restarts the ring at 0
//   f2cBase_in            ring base (QW address)
//   mtrBase_in            metrics buffer base (QW address)
//   rdPtr_in/rdPtrWr_in   host read-pointer and its write strobe
//   srcData_in/srcValid_in/srcReady_out        source stream
//   txReq_out/txAck_in/txAddr_out/txLenDW_out  TLP header handshake
//   txData_out/txDataValid_out/txDataReady_in  TLP payload handshake
//   wrPtr_out             registered chunk write-pointer
//   busy_out              FSM not idle
//
// State table
//   state        | meaning
//   S_IDLE       | DMA disabled, nothing in flight
//   S_WAIT_SPACE | chunk boundary, waiting for a free ring slot
//   S_DATA_HDR   | presenting a data TLP header
//   S_PAYLOAD    | streaming TLP_QWS source beats straight to the transmitter
//   S_MTR_HDR    | presenting the metrics TLP header
//   S_MTR_BEAT   | presenting the new write-pointer as the metrics payload
//
// The outputs are decoded only from the registered state. The one exception is
// the payload path, which is a pure combinational pass-through of the source
// handshake, so that streaming adds no latency.
// ----------------------------------------------------------------------------
module f2c_dma_scheduler #(
   parameter int PTR_BITS       = 2,
   parameter int TLPS_PER_CHUNK = 4,
   parameter int TLP_QWS        = 16
) (
   input  logic                clk_in,
   input  logic                rstn,
   input  logic                dmaEnable_in,
   input  logic [31:0]         f2cBase_in,
   input  logic [31:0]         mtrBase_in,
   input  logic [PTR_BITS-1:0] rdPtr_in,
   input  logic                rdPtrWr_in,
   input  logic [63:0]         srcData_in,
   input  logic                srcValid_in,
   output logic                srcReady_out,
   output logic                txReq_out,
   input  logic                txAck_in,
   output logic [31:0]         txAddr_out,
   output logic [9:0]          txLenDW_out,
   output logic [63:0]         txData_out,
   output logic                txDataValid_out,
   input  logic                txDataReady_in,
   output logic [PTR_BITS-1:0] wrPtr_out,
   output logic                busy_out
);

   localparam int TLP_BITS  = (TLPS_PER_CHUNK > 1) ? $clog2(TLPS_PER_CHUNK) : 1;
   localparam int BEAT_BITS = (TLP_QWS > 1) ? $clog2(TLP_QWS) : 1;

   localparam logic [TLP_BITS-1:0]  LAST_TLP    = TLP_BITS'(TLPS_PER_CHUNK - 1);
   localparam logic [BEAT_BITS-1:0] LAST_BEAT   = BEAT_BITS'(TLP_QWS - 1);
   localparam logic [31:0]          CHUNK_MUL   = 32'(TLPS_PER_CHUNK);
   localparam logic [31:0]          QW_MUL      = 32'(TLP_QWS);
   localparam logic [9:0]           DATA_LEN_DW = 10'(2 * TLP_QWS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SPACE,
      S_DATA_HDR,
      S_PAYLOAD,
      S_MTR_HDR,
      S_MTR_BEAT
   } state_t;

   state_t               r_state;
   logic [PTR_BITS-1:0]  r_wr_ptr;
   logic [PTR_BITS-1:0]  r_rd_ptr;
   logic [TLP_BITS-1:0]  r_tlp;
   logic [BEAT_BITS-1:0] r_beat;
   logic                 r_en_d;

   logic                 w_en_rise;
   logic                 w_full;
   logic                 w_hdr_fire;
   logic                 w_beat_fire;
   logic [PTR_BITS-1:0]  w_wr_ptr_inc;
   logic [31:0]          w_data_addr;

   assign w_en_rise    = dmaEnable_in & ~r_en_d;
   assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
   assign w_full       = (w_wr_ptr_inc == r_rd_ptr);
   assign w_hdr_fire   = txReq_out & txAck_in;
   assign w_beat_fire  = txDataValid_out & txDataReady_in;

   // Slot index (chunk * TLPs-per-chunk + tlp) scaled to QWs, wraps mod 2^32.
   assign w_data_addr = f2cBase_in + ((32'(r_wr_ptr) * CHUNK_MUL) + 32'(r_tlp)) * QW_MUL;

   always_ff @(posedge clk_in) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_tlp    <= '0;
         r_beat   <= '0;
         r_en_d   <= 1'b0;
      end else begin
         r_en_d <= dmaEnable_in;

         // A host write beats the restart clear so that a pointer update is never lost.
         if (rdPtrWr_in)
            r_rd_ptr <= rdPtr_in;
         else if (w_en_rise)
            r_rd_ptr <= '0;

         if (w_en_rise)
            r_wr_ptr <= '0;

         case (r_state)
            S_IDLE: begin
               if (dmaEnable_in)
                  r_state <= S_WAIT_SPACE;
            end
            S_WAIT_SPACE: begin
               if (!dmaEnable_in) begin
                  r_state <= S_IDLE;
               end else if (!w_full) begin
                  r_tlp   <= '0;
                  r_state <= S_DATA_HDR;
               end
            end
            S_DATA_HDR: begin
               if (w_hdr_fire) begin
                  r_beat  <= '0;
                  r_state <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (w_beat_fire) begin
                  if (r_beat == LAST_BEAT) begin
                     if (r_tlp == LAST_TLP) begin
                        // The pointer only moves once the whole chunk is in the ring.
                        r_wr_ptr <= w_wr_ptr_inc;
                        r_state  <= S_MTR_HDR;
                     end else begin
                        r_tlp   <= r_tlp + 1'b1;
                        r_state <= S_DATA_HDR;
                     end
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            S_MTR_HDR: begin
               if (w_hdr_fire)
                  r_state <= S_MTR_BEAT;
            end
            S_MTR_BEAT: begin
               if (w_beat_fire)
                  r_state <= dmaEnable_in ? S_WAIT_SPACE : S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      txReq_out       = 1'b0;
      txAddr_out      = '0;
      txLenDW_out     = '0;
      txData_out      = '0;
      txDataValid_out = 1'b0;
      srcReady_out    = 1'b0;
      case (r_state)
         S_DATA_HDR: begin
            txReq_out   = 1'b1;
            txAddr_out  = w_data_addr;
            txLenDW_out = DATA_LEN_DW;
         end
         S_PAYLOAD: begin
            txData_out      = srcData_in;
            txDataValid_out = srcValid_in;
            srcReady_out    = txDataReady_in;
         end
         S_MTR_HDR: begin
            txReq_out   = 1'b1;
            txAddr_out  = mtrBase_in;
            txLenDW_out = 10'd1;
         end
         S_MTR_BEAT: begin
            txDataValid_out = 1'b1;
            txData_out      = 64'(r_wr_ptr);
         end
         default: ;
      endcase
   end

   assign wrPtr_out = r_wr_ptr;
   assign busy_out  = (r_state != S_IDLE);

endmodule

// File: tb/tb_f2c_dma_scheduler.sv
`timescale 1ns/1ps
module tb_f2c_dma_scheduler;

   localparam int PTR_BITS = 2;
   localparam int TMO      = 600;

   logic                clk_in = 1'b0;
   logic                rstn;
   logic                dmaEnable_in;
   logic [31:0]         f2cBase_in;
   logic [31:0]         mtrBase_in;
   logic [PTR_BITS-1:0] rdPtr_in;
   logic                rdPtrWr_in;
   logic [63:0]         srcData_in;
   logic                srcValid_in;
   logic                srcReady_out;
   logic                txReq_out;
   logic                txAck_in;
   logic [31:0]         txAddr_out;
   logic [9:0]          txLenDW_out;
   logic [63:0]         txData_out;
   logic                txDataValid_out;
   logic                txDataReady_in;
   logic [PTR_BITS-1:0] wrPtr_out;
   logic                busy_out;

   always #5 clk_in = ~clk_in;

   f2c_dma_scheduler #(.PTR_BITS(PTR_BITS), .TLPS_PER_CHUNK(4), .TLP_QWS(16)) dut (
      .clk_in          (clk_in),
      .rstn            (rstn),
      .dmaEnable_in    (dmaEnable_in),
      .f2cBase_in      (f2cBase_in),
      .mtrBase_in      (mtrBase_in),
      .rdPtr_in        (rdPtr_in),
      .rdPtrWr_in      (rdPtrWr_in),
      .srcData_in      (srcData_in),
      .srcValid_in     (srcValid_in),
      .srcReady_out    (srcReady_out),
      .txReq_out       (txReq_out),
      .txAck_in        (txAck_in),
      .txAddr_out      (txAddr_out),
      .txLenDW_out     (txLenDW_out),
      .txData_out      (txData_out),
      .txDataValid_out (txDataValid_out),
      .txDataReady_in  (txDataReady_in),
      .wrPtr_out       (wrPtr_out),
      .busy_out        (busy_out)
   );

   typedef struct {
      logic [31:0] addr;
      logic [9:0]  len;
      int          bstart;
   } hdr_t;

   typedef struct {
      logic [31:0] addr;
      logic [9:0]  len;
      logic [63:0] mdata;
   } tlp_vec_t;

   hdr_t        hq[$];
   logic [63:0] bq[$];
   int          n_hdr = 0;
   int          n_beat = 0;
   int          stab_obs = 0;
   int          stab_viol = 0;
   bit          mon_rst = 1'b1;
   bit          mon_src_fire = 1'b0;
   bit          prev_pend = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [9:0]  prev_len = '0;
   bit          bp_mode = 1'b0;
   int          src_seq = 0;

   int          checks = 0;
   int          errors = 0;
   int          hidx = 0;
   int          bidx = 0;
   int          exp_seq = 0;
   tlp_vec_t    tbl[20];

   function automatic logic [63:0] src_word(input int s);
      return {32'hDA7A_5EED, 32'(s)};
   endfunction

   // Transmitter-side monitor: records every accepted header and beat.
   always @(negedge clk_in) begin
      mon_rst      = !rstn;
      mon_src_fire = srcValid_in && srcReady_out;
      if (txReq_out && txAck_in) begin
         hq.push_back('{txAddr_out, txLenDW_out, bq.size()});
         n_hdr++;
      end
      if (txDataValid_out && txDataReady_in) begin
         bq.push_back(txData_out);
         n_beat++;
      end
      if (txReq_out && prev_pend) begin
         stab_obs++;
         if (txAddr_out !== prev_addr || txLenDW_out !== prev_len)
            stab_viol++;
      end
      prev_pend = txReq_out && !txAck_in;
      prev_addr = txAddr_out;
      prev_len  = txLenDW_out;
   end

   // Source and sink model: an incrementing word stream, with optional random gaps.
   initial begin
      srcValid_in    = 1'b0;
      srcData_in     = '0;
      txAck_in       = 1'b0;
      txDataReady_in = 1'b0;
      forever begin
         @(posedge clk_in); #1;
         if (mon_rst) src_seq = 0;
         else if (mon_src_fire) src_seq++;
         srcData_in = src_word(src_seq);
         if (bp_mode) begin
            srcValid_in    = ($urandom_range(3) != 0);
            txAck_in       = ($urandom_range(2) == 0);
            txDataReady_in = ($urandom_range(3) != 0);
         end else begin
            srcValid_in    = 1'b1;
            txAck_in       = 1'b1;
            txDataReady_in = 1'b1;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in); #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic do_reset();
      rstn         = 1'b0;
      dmaEnable_in = 1'b0;
      rdPtrWr_in   = 1'b0;
      rdPtr_in     = '0;
      repeat (3) tick();
      hidx    = hq.size();
      bidx    = bq.size();
      exp_seq = 0;
      rstn    = 1'b1;
      tick();
   endtask

   task automatic expect_tlp(input string tag, input int row);
      tlp_vec_t    v;
      hdr_t        h;
      int          nb;
      int          n;
      bit          ok;
      logic [63:0] e;
      logic [63:0] act_c;
      logic [63:0] exp_c;
      v  = tbl[row];
      nb = (v.len == 10'd1) ? 1 : 16;
      n  = 0;
      while ((hq.size() <= hidx || bq.size() < bidx + nb) && n < TMO) begin
         tick();
         n++;
      end
      if (hq.size() <= hidx || bq.size() < bidx + nb) begin
         fail_timeout($sformatf("%s_row%0d_wait", tag, row));
         return;
      end
      h = hq[hidx];
      hidx++;
      chk($sformatf("%s_row%0d_addr", tag, row), 64'(h.addr), 64'(v.addr));
      chk($sformatf("%s_row%0d_len", tag, row), 64'(h.len), 64'(v.len));
      chk($sformatf("%s_row%0d_beat_align", tag, row), 64'(h.bstart), 64'(bidx));
      ok    = 1'b1;
      act_c = '0;
      exp_c = '0;
      for (int i = 0; i < nb; i++) begin
         e = (nb == 1) ? v.mdata : src_word(exp_seq + i);
         if (ok) begin
            act_c = bq[bidx + i];
            exp_c = e;
            if (bq[bidx + i] !== e) ok = 1'b0;
         end
      end
      chk($sformatf("%s_row%0d_data", tag, row), act_c, exp_c);
      if (nb > 1) exp_seq += nb;
      bidx += nb;
   endtask

   task automatic run_ring(input bit bp, input string tag);
      do_reset();
      bp_mode      = bp;
      f2cBase_in   = 32'h1000;
      mtrBase_in   = 32'h2000;
      dmaEnable_in = 1'b1;
      for (int r = 0; r < 15; r++) expect_tlp(tag, r);
      repeat (40) tick();
      @(negedge clk_in);
      chk({tag, "_full_no_hdr"}, 64'(hq.size() - hidx), 64'd0);
      chk({tag, "_full_wrptr"}, 64'(wrPtr_out), 64'd3);
      chk({tag, "_full_txreq"}, 64'(txReq_out), 64'd0);
      chk({tag, "_full_busy"}, 64'(busy_out), 64'd1);
      tick();
      rdPtr_in   = 2'd1;
      rdPtrWr_in = 1'b1;
      tick();
      rdPtrWr_in = 1'b0;
      tick();
      @(negedge clk_in);
      chk({tag, "_release_2cyc"}, 64'(txReq_out), 64'd1);
      tick();
      for (int r = 15; r < 20; r++) expect_tlp(tag, r);
      repeat (40) tick();
      @(negedge clk_in);
      chk({tag, "_wrap_no_hdr"}, 64'(hq.size() - hidx), 64'd0);
      chk({tag, "_wrap_wrptr"}, 64'(wrPtr_out), 64'd0);
      tick();
   endtask

   initial begin
      int base;
      int n;

      tbl = '{
         '{32'h1000, 10'd32, 64'd0},
         '{32'h1010, 10'd32, 64'd0},
         '{32'h1020, 10'd32, 64'd0},
         '{32'h1030, 10'd32, 64'd0},
         '{32'h2000, 10'd1,  64'd1},
         '{32'h1040, 10'd32, 64'd0},
         '{32'h1050, 10'd32, 64'd0},
         '{32'h1060, 10'd32, 64'd0},
         '{32'h1070, 10'd32, 64'd0},
         '{32'h2000, 10'd1,  64'd2},
         '{32'h1080, 10'd32, 64'd0},
         '{32'h1090, 10'd32, 64'd0},
         '{32'h10A0, 10'd32, 64'd0},
         '{32'h10B0, 10'd32, 64'd0},
         '{32'h2000, 10'd1,  64'd3},
         '{32'h10C0, 10'd32, 64'd0},
         '{32'h10D0, 10'd32, 64'd0},
         '{32'h10E0, 10'd32, 64'd0},
         '{32'h10F0, 10'd32, 64'd0},
         '{32'h2000, 10'd1,  64'd0}
      };

      rstn         = 1'b0;
      dmaEnable_in = 1'b1;
      f2cBase_in   = 32'h1000;
      mtrBase_in   = 32'h2000;
      rdPtr_in     = '0;
      rdPtrWr_in   = 1'b0;
      bp_mode      = 1'b0;

      // Reset held while the source and sink are eager.
      repeat (3) tick();
      @(negedge clk_in);
      chk("rst_txreq", 64'(txReq_out), 64'd0);
      chk("rst_srcready", 64'(srcReady_out), 64'd0);
      chk("rst_txvalid", 64'(txDataValid_out), 64'd0);
      chk("rst_wrptr", 64'(wrPtr_out), 64'd0);
      chk("rst_busy", 64'(busy_out), 64'd0);
      tick();

      // Basic chunk, ring-full stall, release and wrap: first with a continuous stream, then with random gaps.
      run_ring(1'b0, "ring");
      run_ring(1'b1, "bp");
      chk("bp_hdr_stable_viol", 64'(stab_viol), 64'd0);
      chk("bp_hdr_stall_seen", 64'(stab_obs > 0), 64'd1);
      bp_mode = 1'b0;

      // Enable is dropped while TLP 1 of chunk 0 is in flight.
      do_reset();
      dmaEnable_in = 1'b1;
      base = n_hdr;
      n = 0;
      while (n_hdr < base + 2 && n < TMO) begin
         tick();
         n++;
      end
      if (n_hdr < base + 2) fail_timeout("dis_tlp1_wait");
      repeat (3) tick();
      dmaEnable_in = 1'b0;
      for (int r = 0; r < 5; r++) expect_tlp("dis", r);
      repeat (20) tick();
      @(negedge clk_in);
      chk("dis_idle_busy", 64'(busy_out), 64'd0);
      chk("dis_idle_wrptr", 64'(wrPtr_out), 64'd1);
      chk("dis_idle_no_hdr", 64'(hq.size() - hidx), 64'd0);
      tick();
      dmaEnable_in = 1'b1;
      tick();
      @(negedge clk_in);
      chk("reen_wrptr", 64'(wrPtr_out), 64'd0);
      tick();
      expect_tlp("reen", 0);

      // Reset arrives while beat 7 of the first TLP is being presented.
      do_reset();
      dmaEnable_in = 1'b1;
      base = n_beat;
      n = 0;
      while (n_beat < base + 7 && n < TMO) begin
         tick();
         n++;
      end
      if (n_beat < base + 7) fail_timeout("rstmid_beat7_wait");
      rstn = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      chk("rstmid_txvalid", 64'(txDataValid_out), 64'd0);
      chk("rstmid_busy", 64'(busy_out), 64'd0);
      tick();
      do_reset();
      dmaEnable_in = 1'b1;
      expect_tlp("rstmid", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
